// File: rtl/altera_tse_lvds_loopback_ctrl_pkg.sv
// rtl/altera_tse_lvds_loopback_ctrl_pkg.sv - shared defines for the TSE LVDS loopback controller
package altera_tse_lvds_lb_ctrl_defs;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_FLUSH     = 3'd1,
        ST_WAIT_SYNC = 3'd2,
        ST_ACQUIRE   = 3'd3,
        ST_RUN       = 3'd4
    } lb_state_e;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int width_for(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/altera_tse_sat_counter.sv
// rtl/altera_tse_sat_counter.sv - saturating up-counter with synchronous clear
module altera_tse_sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             wclk,
    input  logic             reset_wclk,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge wclk or posedge reset_wclk) begin
        if (reset_wclk) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/altera_tse_lvds_loopback_ctrl.sv
// rtl/altera_tse_lvds_loopback_ctrl.sv - loopback bring-up FSM, FIFO write gating and statistics
module altera_tse_lvds_loopback_ctrl
    import altera_tse_lvds_lb_ctrl_defs::*;
#(
    parameter int FLUSH_CYCLES = 8,
    parameter int SYNC_TIMEOUT = 1024,
    parameter int IDLE_TARGET  = 4,
    parameter int OVF_LIMIT    = 64,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 wclk,
    input  logic                 reset_wclk,
    input  logic                 loopback_en,
    input  logic                 align_sync,
    input  logic                 rx_idle_detect,
    input  logic                 rm_delete,
    input  logic                 ff_afull,
    input  logic                 stat_clear,
    output logic                 ff_flush,
    output logic                 ff_wr_gate,
    output logic                 loopback_active,
    output logic [STATE_W-1:0]   state,
    output logic [CNT_WIDTH-1:0] delete_cnt,
    output logic [7:0]           resync_cnt,
    output logic                 err_timeout,
    output logic                 err_overflow
);

    localparam int FL_W = width_for(FLUSH_CYCLES);
    localparam int TM_W = width_for(SYNC_TIMEOUT);
    localparam int ID_W = width_for(IDLE_TARGET);
    localparam int OV_W = width_for(OVF_LIMIT);

    lb_state_e       cur_st;
    logic [FL_W-1:0] flush_cnt;
    logic [TM_W-1:0] sync_tmr;
    logic [ID_W-1:0] idle_cnt;
    logic [OV_W-1:0] ovf_cnt;

    logic ovf_hit;
    logic timeout_hit;
    logic run_exit;
    logic del_inc;

    always_comb begin
        ovf_hit     = (cur_st == ST_RUN) && loopback_en && ff_afull && !rm_delete
                      && (ovf_cnt == OV_W'(OVF_LIMIT - 1));
        timeout_hit = (cur_st == ST_WAIT_SYNC) && loopback_en && !align_sync
                      && (sync_tmr == TM_W'(SYNC_TIMEOUT - 1));
        run_exit    = (cur_st == ST_RUN) && loopback_en && (!align_sync || ovf_hit);
        del_inc     = (cur_st == ST_RUN) && rm_delete;
    end

    // Outputs are registered alongside the state so they track it exactly.
    always_ff @(posedge wclk or posedge reset_wclk) begin
        if (reset_wclk) begin
            cur_st          <= ST_IDLE;
            flush_cnt       <= '0;
            sync_tmr        <= '0;
            idle_cnt        <= '0;
            ovf_cnt         <= '0;
            ff_flush        <= 1'b0;
            ff_wr_gate      <= 1'b0;
            loopback_active <= 1'b0;
        end else begin
            ovf_cnt <= '0;
            if (!loopback_en) begin
                cur_st          <= ST_IDLE;
                ff_flush        <= 1'b0;
                ff_wr_gate      <= 1'b0;
                loopback_active <= 1'b0;
            end else begin
                case (cur_st)
                    ST_IDLE: begin
                        cur_st    <= ST_FLUSH;
                        flush_cnt <= '0;
                        ff_flush  <= 1'b1;
                    end
                    ST_FLUSH: begin
                        if (flush_cnt == FL_W'(FLUSH_CYCLES - 1)) begin
                            cur_st   <= ST_WAIT_SYNC;
                            sync_tmr <= '0;
                            ff_flush <= 1'b0;
                        end else begin
                            flush_cnt <= flush_cnt + 1'b1;
                        end
                    end
                    ST_WAIT_SYNC: begin
                        if (align_sync) begin
                            cur_st   <= ST_ACQUIRE;
                            idle_cnt <= '0;
                        end else if (timeout_hit) begin
                            cur_st    <= ST_FLUSH;
                            flush_cnt <= '0;
                            ff_flush  <= 1'b1;
                        end else begin
                            sync_tmr <= sync_tmr + 1'b1;
                        end
                    end
                    ST_ACQUIRE: begin
                        if (!align_sync) begin
                            cur_st   <= ST_WAIT_SYNC;
                            sync_tmr <= '0;
                            idle_cnt <= '0;
                        end else if (rx_idle_detect) begin
                            if (idle_cnt == ID_W'(IDLE_TARGET - 1)) begin
                                cur_st          <= ST_RUN;
                                ff_wr_gate      <= 1'b1;
                                loopback_active <= 1'b1;
                            end else begin
                                idle_cnt <= idle_cnt + 1'b1;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (run_exit) begin
                            cur_st          <= ST_FLUSH;
                            flush_cnt       <= '0;
                            ff_flush        <= 1'b1;
                            ff_wr_gate      <= 1'b0;
                            loopback_active <= 1'b0;
                        end else if (ff_afull && !rm_delete) begin
                            ovf_cnt <= ovf_cnt + 1'b1;
                        end
                    end
                    default: begin
                        cur_st          <= ST_IDLE;
                        ff_flush        <= 1'b0;
                        ff_wr_gate      <= 1'b0;
                        loopback_active <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge wclk or posedge reset_wclk) begin
        if (reset_wclk) begin
            err_timeout  <= 1'b0;
            err_overflow <= 1'b0;
        end else if (stat_clear) begin
            err_timeout  <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            if (timeout_hit) begin
                err_timeout <= 1'b1;
            end
            if (ovf_hit) begin
                err_overflow <= 1'b1;
            end
        end
    end

    assign state = cur_st;

    altera_tse_sat_counter #(
        .WIDTH(CNT_WIDTH)
    ) u_delete_cnt (
        .wclk       (wclk),
        .reset_wclk (reset_wclk),
        .inc        (del_inc),
        .clr        (stat_clear),
        .count      (delete_cnt)
    );

    altera_tse_sat_counter #(
        .WIDTH(8)
    ) u_resync_cnt (
        .wclk       (wclk),
        .reset_wclk (reset_wclk),
        .inc        (run_exit),
        .clr        (stat_clear),
        .count      (resync_cnt)
    );

endmodule

// File: tb/tb_altera_tse_lvds_loopback_ctrl.sv
// tb/tb_altera_tse_lvds_loopback_ctrl.sv - self-checking bench for altera_tse_lvds_loopback_ctrl
module tb_altera_tse_lvds_loopback_ctrl;

    localparam int FLUSH_CYCLES = 8;
    localparam int SYNC_TIMEOUT = 1024;
    localparam int IDLE_TARGET  = 4;
    localparam int OVF_LIMIT    = 64;
    localparam int CNT_WIDTH    = 4;
    localparam int D_MAX        = (1 << CNT_WIDTH) - 1;

    localparam int S_IDLE  = 0;
    localparam int S_FLUSH = 1;
    localparam int S_WAIT  = 2;
    localparam int S_ACQ   = 3;
    localparam int S_RUN   = 4;

    logic                 wclk = 1'b0;
    logic                 reset_wclk;
    logic                 loopback_en;
    logic                 align_sync;
    logic                 rx_idle_detect;
    logic                 rm_delete;
    logic                 ff_afull;
    logic                 stat_clear;
    logic                 ff_flush;
    logic                 ff_wr_gate;
    logic                 loopback_active;
    logic [2:0]           state;
    logic [CNT_WIDTH-1:0] delete_cnt;
    logic [7:0]           resync_cnt;
    logic                 err_timeout;
    logic                 err_overflow;

    altera_tse_lvds_loopback_ctrl #(
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .SYNC_TIMEOUT (SYNC_TIMEOUT),
        .IDLE_TARGET  (IDLE_TARGET),
        .OVF_LIMIT    (OVF_LIMIT),
        .CNT_WIDTH    (CNT_WIDTH)
    ) dut (
        .wclk            (wclk),
        .reset_wclk      (reset_wclk),
        .loopback_en     (loopback_en),
        .align_sync      (align_sync),
        .rx_idle_detect  (rx_idle_detect),
        .rm_delete       (rm_delete),
        .ff_afull        (ff_afull),
        .stat_clear      (stat_clear),
        .ff_flush        (ff_flush),
        .ff_wr_gate      (ff_wr_gate),
        .loopback_active (loopback_active),
        .state           (state),
        .delete_cnt      (delete_cnt),
        .resync_cnt      (resync_cnt),
        .err_timeout     (err_timeout),
        .err_overflow    (err_overflow)
    );

    always #5 wclk = ~wclk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: time spent in the current state plus event tallies.
    int m_state, m_age, m_idles, m_ovf, m_d, m_r, m_et, m_eo;

    typedef struct {
        logic en, sync, idle, afull, del, clr;
        int   n;
        int   st, d, r, et, eo;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic en, input logic sync, input logic idle,
                                input logic afull, input logic del, input logic clr,
                                input int n, input int st, input int d, input int r,
                                input int et, input int eo);
        vec_t v;
        v.en = en; v.sync = sync; v.idle = idle; v.afull = afull; v.del = del; v.clr = clr;
        v.n = n; v.st = st; v.d = d; v.r = r; v.et = et; v.eo = eo;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE; m_age = 0; m_idles = 0; m_ovf = 0;
        m_d = 0; m_r = 0; m_et = 0; m_eo = 0;
    endtask

    task automatic model_step();
        int nxt;
        bit ovfhit;
        bit to;
        nxt = m_state; ovfhit = 0; to = 0;
        if (!loopback_en) begin
            nxt = S_IDLE;
        end else begin
            case (m_state)
                S_IDLE:  nxt = S_FLUSH;
                S_FLUSH: if (m_age + 1 == FLUSH_CYCLES) nxt = S_WAIT;
                S_WAIT: begin
                    if (align_sync) nxt = S_ACQ;
                    else if (m_age + 1 == SYNC_TIMEOUT) begin nxt = S_FLUSH; to = 1; end
                end
                S_ACQ: begin
                    if (!align_sync) nxt = S_WAIT;
                    else if (rx_idle_detect && (m_idles + 1 == IDLE_TARGET)) nxt = S_RUN;
                end
                S_RUN: begin
                    ovfhit = ff_afull && !rm_delete && (m_ovf + 1 == OVF_LIMIT);
                    if (!align_sync || ovfhit) nxt = S_FLUSH;
                end
                default: nxt = S_IDLE;
            endcase
        end
        if (stat_clear) begin
            m_d = 0; m_r = 0; m_et = 0; m_eo = 0;
        end else begin
            if (m_state == S_RUN && rm_delete && m_d < D_MAX) m_d++;
            if (m_state == S_RUN && nxt == S_FLUSH && m_r < 255) m_r++;
            if (to) m_et = 1;
            if (ovfhit) m_eo = 1;
        end
        m_ovf   = (m_state == S_RUN && nxt == S_RUN && ff_afull && !rm_delete) ? m_ovf + 1 : 0;
        m_idles = (m_state == S_ACQ && nxt == S_ACQ) ? m_idles + int'(rx_idle_detect) : 0;
        m_age   = (nxt == m_state) ? m_age + 1 : 0;
        m_state = nxt;
    endtask

    task automatic compare_model();
        check("state", int'(state), m_state);
        check("ff_flush", int'(ff_flush), int'(m_state == S_FLUSH));
        check("ff_wr_gate", int'(ff_wr_gate), int'(m_state == S_RUN));
        check("loopback_active", int'(loopback_active), int'(m_state == S_RUN));
        check("delete_cnt", int'(delete_cnt), m_d);
        check("resync_cnt", int'(resync_cnt), m_r);
        check("err_timeout", int'(err_timeout), m_et);
        check("err_overflow", int'(err_overflow), m_eo);
    endtask

    task automatic tick();
        @(posedge wclk);
        if (!reset_wclk) model_step();
        @(negedge wclk);
        compare_model();
    endtask

    task automatic apply(input vec_t v);
        loopback_en = v.en; align_sync = v.sync; rx_idle_detect = v.idle;
        ff_afull = v.afull; rm_delete = v.del; stat_clear = v.clr;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seg_left;
        logic afull_lvl;
        int bound;

        // en, sync, idle, afull, del, clr, n, state, delete, resync, err_t, err_o
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,    1, S_FLUSH, 0,  0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,    7, S_FLUSH, 0,  0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,    1, S_WAIT,  0,  0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0,    1, S_ACQ,   0,  0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 0,    3, S_ACQ,   0,  0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 0,    1, S_RUN,   0,  0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 1, 0,   20, S_RUN,  15,  0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 1, 1,    1, S_RUN,   0,  0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,    1, S_FLUSH, 0,  1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0,    8, S_WAIT,  0,  1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0,    1, S_ACQ,   0,  1, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 0,    4, S_RUN,   0,  1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 1, 0, 0,   63, S_RUN,   0,  1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 1, 0, 0,    1, S_FLUSH, 0,  2, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0,    8, S_WAIT,  0,  2, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0,    1, S_ACQ,   0,  2, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0, 0, 1,    1, S_ACQ,   0,  0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 0,    4, S_RUN,   0,  0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 1, 0, 0,   39, S_RUN,   0,  0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 1, 1, 0,    1, S_RUN,   1,  0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 1, 0, 0,   40, S_RUN,   1,  0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0,    1, S_IDLE,  1,  0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0,    1, S_FLUSH, 1,  0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0,    8, S_WAIT,  1,  0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0,    1, S_ACQ,   1,  0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0,    1, S_IDLE,  1,  0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,    1, S_FLUSH, 1,  0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,    8, S_WAIT,  1,  0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1023, S_WAIT,  1,  0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,    1, S_FLUSH, 1,  0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1,    1, S_FLUSH, 0,  0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,    7, S_WAIT,  0,  0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1023, S_WAIT,  0,  0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0,    1, S_ACQ,   0,  0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 0,    4, S_RUN,   0,  0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 1, 0, 0,   63, S_RUN,   0,  0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0,    1, S_FLUSH, 0,  1, 0, 1));

        reset_wclk = 1'b1;
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        model_reset();
        repeat (3) tick();
        reset_wclk = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
            repeat (vecs[i].n) tick();
            check($sformatf("vec%0d.state", i), int'(state), vecs[i].st);
            check($sformatf("vec%0d.ff_flush", i), int'(ff_flush), int'(vecs[i].st == S_FLUSH));
            check($sformatf("vec%0d.ff_wr_gate", i), int'(ff_wr_gate), int'(vecs[i].st == S_RUN));
            check($sformatf("vec%0d.active", i), int'(loopback_active), int'(vecs[i].st == S_RUN));
            check($sformatf("vec%0d.delete_cnt", i), int'(delete_cnt), vecs[i].d);
            check($sformatf("vec%0d.resync_cnt", i), int'(resync_cnt), vecs[i].r);
            check($sformatf("vec%0d.err_timeout", i), int'(err_timeout), vecs[i].et);
            check($sformatf("vec%0d.err_overflow", i), int'(err_overflow), vecs[i].eo);
        end

        seg_left = 0;
        afull_lvl = 1'b0;
        for (int c = 0; c < 6000; c++) begin
            if (seg_left == 0) begin
                seg_left  = $urandom_range(1, 100);
                afull_lvl = ($urandom_range(0, 2) == 0);
            end
            seg_left--;
            loopback_en    = ($urandom_range(0, 299) != 0);
            align_sync     = ($urandom_range(0, 79) != 0);
            rx_idle_detect = ($urandom_range(0, 3) == 0);
            rm_delete      = ($urandom_range(0, 59) == 0);
            ff_afull       = afull_lvl;
            stat_clear     = ($urandom_range(0, 399) == 0);
            tick();
        end

        // Asynchronous reset in the middle of a flush.
        apply(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        bound = 0;
        while (m_state != S_FLUSH && bound < 20) begin
            tick();
            bound++;
        end
        check("reach_flush", m_state, S_FLUSH);
        tick();
        #2;
        reset_wclk = 1'b1;
        #1;
        model_reset();
        check("rst.state", int'(state), S_IDLE);
        check("rst.ff_flush", int'(ff_flush), 0);
        check("rst.ff_wr_gate", int'(ff_wr_gate), 0);
        check("rst.active", int'(loopback_active), 0);
        check("rst.delete_cnt", int'(delete_cnt), 0);
        check("rst.resync_cnt", int'(resync_cnt), 0);
        check("rst.err_timeout", int'(err_timeout), 0);
        check("rst.err_overflow", int'(err_overflow), 0);
        tick();
        reset_wclk = 1'b0;
        tick();
        check("post_rst.state", int'(state), S_FLUSH);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
